// File: rtl/line_win_ctrl.sv
// line_win_ctrl: sequences pixels into a line buffer and reports which
// vertical window column (centre row/col) the buffer taps hold each cycle.
// After the last input line a synthetic all-zero line is pushed so the
// final image row also gets its windows.
module line_win_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              pix_valid,
  input  logic                              pix_sof,
  input  logic [DATA_WIDTH-1:0]             pix_data,
  output logic                              pix_ready,
  output logic                              buf_clken,
  output logic [DATA_WIDTH-1:0]             buf_shiftin,
  output logic                              win_valid,
  output logic [$clog2(IMG_HEIGHT+1)-1:0]   win_row,
  output logic [$clog2(IMG_WIDTH+1)-1:0]    win_col,
  output logic                              win_border,
  output logic                              frame_done,
  output logic                              err_sof
);

  localparam int RW = $clog2(IMG_HEIGHT + 1);
  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] FLUSH_ROW = RW'(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t        state, state_next;
  logic [CW-1:0] col, col_next, col_adv;
  logic [RW-1:0] row, row_next, row_adv;
  logic          accept;
  logic          col_last;
  logic          err_det;
  logic          win_det;

  // FLUSH never takes input; reset also blocks acceptance.
  assign pix_ready = !reset && (state != FLUSH);
  assign accept    = pix_valid && pix_ready;
  assign col_last  = (col == LAST_COL);
  // A buffer shift at row >= 1 means the taps will hold a full column next cycle.
  assign win_det   = buf_clken && (row != '0);

  // Raster position one step ahead of the current one.
  always_comb begin
    col_adv = col + CW'(1);
    row_adv = row;
    if (col_last) begin
      col_adv = '0;
      row_adv = row + RW'(1);
    end
  end

  // Next-state, counter update and line-buffer drive.
  always_comb begin
    state_next  = state;
    col_next    = col;
    row_next    = row;
    buf_clken   = 1'b0;
    buf_shiftin = '0;
    err_det     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (pix_sof) begin
            buf_clken  = 1'b1;
            col_next   = col_adv;
            row_next   = row_adv;
            state_next = col_last ? RUN : FILL;
          end else begin
            err_det = 1'b1;
          end
        end
      end
      FILL: begin
        if (accept) begin
          buf_clken = 1'b1;
          err_det   = pix_sof;
          col_next  = col_adv;
          row_next  = row_adv;
          if (col_last) state_next = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          buf_clken = 1'b1;
          err_det   = pix_sof;
          col_next  = col_adv;
          row_next  = row_adv;
          if (col_last && (row == LAST_ROW)) state_next = FLUSH;
        end
      end
      FLUSH: begin
        buf_clken = 1'b1;
        col_next  = col_adv;
        row_next  = row_adv;
        if (col_last) begin
          state_next = IDLE;
          col_next   = '0;
          row_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
    if (accept) buf_shiftin = pix_data;
    if (reset) buf_clken = 1'b0;
  end

  // State, raster counters and registered window/status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      win_border <= 1'b0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      state      <= state_next;
      col        <= col_next;
      row        <= row_next;
      win_valid  <= win_det;
      win_row    <= win_det ? (row - RW'(1)) : '0;
      win_col    <= win_det ? col : '0;
      win_border <= win_det && ((row == RW'(1)) || (row == FLUSH_ROW) ||
                                (col == '0) || col_last);
      frame_done <= win_det && (row == FLUSH_ROW) && col_last;
      err_sof    <= err_det;
    end
  end

endmodule

// File: tb/tb_line_win_ctrl.sv
// tb_line_win_ctrl: scoreboard bench for line_win_ctrl on a 4x3 image.
module tb_line_win_ctrl;

  localparam int W = 4;
  localparam int H = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       pix_valid;
  logic       pix_sof;
  logic [7:0] pix_data;
  logic       pix_ready;
  logic       buf_clken;
  logic [7:0] buf_shiftin;
  logic       win_valid;
  logic [1:0] win_row;
  logic [2:0] win_col;
  logic       win_border;
  logic       frame_done;
  logic       err_sof;

  typedef struct packed {
    logic [1:0] row;
    logic [2:0] col;
    logic       border;
    logic       done;
  } win_t;

  win_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   clken_cnt = 0;
  int   err_cnt = 0;
  int   done_cnt = 0;

  line_win_ctrl #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clock(clock), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .pix_ready(pix_ready), .buf_clken(buf_clken),
    .buf_shiftin(buf_shiftin), .win_valid(win_valid), .win_row(win_row),
    .win_col(win_col), .win_border(win_border), .frame_done(frame_done),
    .err_sof(err_sof)
  );

  // 10-time-unit clock.
  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Expected windows of a frame in raster order, optionally truncated.
  task automatic push_frame(input int nwin);
    int n = 0;
    win_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < nwin) begin
          e.row    = 2'(r);
          e.col    = 3'(c);
          e.border = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
          e.done   = (r == H - 1) && (c == W - 1);
          exp_q.push_back(e);
        end
        n++;
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever a window is presented.
  always @(negedge clock) begin
    win_t e;
    if (buf_clken) clken_cnt++;
    if (err_sof) err_cnt++;
    if (frame_done) done_cnt++;
    if (win_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_window", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("win_row", int'(win_row), int'(e.row));
        check("win_col", int'(win_col), int'(e.col));
        check("win_border", int'(win_border), int'(e.border));
        check("frame_done", int'(frame_done), int'(e.done));
      end
    end else begin
      check("flags_without_window", int'({win_border, frame_done}), 0);
    end
  end

  // Offer one pixel until accepted; reports how many cycles it was held off.
  task automatic send_pixel(input logic [7:0] d, input logic sof, input logic exp_clk,
                            output int stalls);
    logic ok = 1'b0;
    stalls = 0;
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = d;
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      ok = pix_ready;
      if (ok) begin
        check("clken_on_accept", int'(buf_clken), int'(exp_clk));
        if (exp_clk) check("shiftin_on_accept", int'(buf_shiftin), int'(d));
      end
      @(posedge clock);
      #1;
      if (ok) break;
      stalls++;
    end
    if (!ok) check("accept_timeout", 0, 1);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
  endtask

  task automatic idle_cycle();
    @(posedge clock);
    #1;
  endtask

  // Send a 12-pixel frame: sof on pixel 0, stray sof on pixel bad_sof (-1 none).
  task automatic send_frame(input int bad_sof, input bit gaps);
    int st;
    for (int i = 0; i < W * H; i++) begin
      if (gaps && i != 0 && $urandom_range(0, 1) == 1) idle_cycle();
      send_pixel(8'(i + 1), (i == 0) || (i == bad_sof), 1'b1, st);
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 30 && exp_q.size() != 0; t++) @(posedge clock);
    repeat (2) @(posedge clock);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic applyStimulus();
    int c0, e0, d0, st;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
    reset     = 1'b1;

    // Reset state.
    repeat (2) begin
      @(negedge clock);
      check("rst_pix_ready", int'(pix_ready), 0);
      check("rst_buf_clken", int'(buf_clken), 0);
      check("rst_win_valid", int'(win_valid), 0);
      check("rst_err_sof", int'(err_sof), 0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle_cycle();

    // Gapless frame and the FLUSH line that follows it.
    c0 = clken_cnt; d0 = done_cnt; e0 = err_cnt;
    push_frame(12);
    send_frame(-1, 1'b0);
    for (int k = 0; k < W; k++) begin
      @(negedge clock);
      check("flush_pix_ready", int'(pix_ready), 0);
      check("flush_clken", int'(buf_clken), 1);
      check("flush_shiftin", int'(buf_shiftin), 0);
    end
    @(negedge clock);
    check("after_flush_ready", int'(pix_ready), 1);
    wait_drain();
    check("gapless_clken_count", clken_cnt - c0, 16);
    check("gapless_done_count", done_cnt - d0, 1);
    check("gapless_err_count", err_cnt - e0, 0);

    // Same frame with ~50% valid duty.
    c0 = clken_cnt; d0 = done_cnt;
    push_frame(12);
    send_frame(-1, 1'b1);
    wait_drain();
    check("gappy_clken_count", clken_cnt - c0, 16);
    check("gappy_done_count", done_cnt - d0, 1);

    // Pixel without sof in IDLE is dropped with an error pulse.
    c0 = clken_cnt; e0 = err_cnt;
    send_pixel(8'hAA, 1'b0, 1'b0, st);
    repeat (3) idle_cycle();
    check("idle_nosof_err", err_cnt - e0, 1);
    check("idle_nosof_clken", clken_cnt - c0, 0);
    check("idle_nosof_no_window", exp_q.size(), 0);

    // Stray sof mid-frame: error pulse, frame continues normally.
    c0 = clken_cnt; e0 = err_cnt; d0 = done_cnt;
    push_frame(12);
    send_frame(5, 1'b0);
    wait_drain();
    check("midsof_err", err_cnt - e0, 1);
    check("midsof_clken_count", clken_cnt - c0, 16);
    check("midsof_done_count", done_cnt - d0, 1);

    // Reset during the second FLUSH cycle abandons the frame.
    c0 = clken_cnt; d0 = done_cnt;
    push_frame(9);
    send_frame(-1, 1'b0);
    idle_cycle();
    reset = 1'b1;
    @(negedge clock);
    check("rstflush_pix_ready", int'(pix_ready), 0);
    check("rstflush_clken", int'(buf_clken), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rstflush_win_valid", int'(win_valid), 0);
    check("rstflush_win_row", int'(win_row), 0);
    check("rstflush_win_col", int'(win_col), 0);
    check("rstflush_border", int'(win_border), 0);
    check("rstflush_done", int'(frame_done), 0);
    check("rstflush_err", int'(err_sof), 0);
    check("rstflush_idle_ready", int'(pix_ready), 1);
    idle_cycle();
    idle_cycle();
    check("rstflush_scoreboard", exp_q.size(), 0);
    check("rstflush_no_done", done_cnt - d0, 0);
    check("rstflush_clken_count", clken_cnt - c0, 13);

    // A normal frame after the abandoned one.
    d0 = done_cnt;
    push_frame(12);
    send_frame(-1, 1'b0);
    wait_drain();
    check("post_rst_done", done_cnt - d0, 1);

    // Back-to-back frames: the next sof waits out FLUSH.
    c0 = clken_cnt; d0 = done_cnt;
    push_frame(12);
    push_frame(12);
    send_frame(-1, 1'b0);
    send_pixel(8'd1, 1'b1, 1'b1, st);
    check("b2b_sof_stall_cycles", st, W);
    for (int i = 1; i < W * H; i++) send_pixel(8'(i + 1), 1'b0, 1'b1, st);
    wait_drain();
    check("b2b_done_count", done_cnt - d0, 2);
    check("b2b_clken_count", clken_cnt - c0, 32);
  endtask

  task automatic checkOutput();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $finish;
  end

  // Run-time bound so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
